// File: rtl/mul_pipe_if.sv
// Issue/result handshake bundle for mul_pipe: issuer drives master, multiplier implements slave.
interface mul_pipe_if #(
  parameter int W      = 64,
  parameter int LG_ROB = 6,
  parameter int LG_PRF = 7
);
  logic              go;
  logic              in_ready;
  logic [2:0]        op;
  logic [W-1:0]      src_a;
  logic [W-1:0]      src_b;
  logic [LG_ROB-1:0] rob_ptr_in;
  logic [LG_PRF-1:0] prf_ptr_in;
  logic              out_ready;
  logic              complete;
  logic [W-1:0]      y;
  logic [LG_ROB-1:0] rob_ptr_out;
  logic [LG_PRF-1:0] prf_ptr_out;

  modport master (
    output go, op, src_a, src_b, rob_ptr_in, prf_ptr_in, out_ready,
    input  in_ready, complete, y, rob_ptr_out, prf_ptr_out
  );

  modport slave (
    input  go, op, src_a, src_b, rob_ptr_in, prf_ptr_in, out_ready,
    output in_ready, complete, y, rob_ptr_out, prf_ptr_out
  );
endinterface

// File: rtl/mul_pipe.sv
// Pipelined RV64 MUL/MULH/MULHSU/MULHU/MULW unit carrying ROB/PRF tags; MUL_PIPE_PERF_EN adds perf counters.
// Latency: LAT cycles issue-to-complete, one op per cycle.
// Backpressure: complete & ~out_ready freezes every stage and drops in_ready; flush kills all in-flight ops.
module mul_pipe #(
  parameter int W      = 64,
  parameter int LAT    = 4,
  parameter int LG_ROB = 6,
  parameter int LG_PRF = 7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  mul_pipe_if.slave   bus
`ifdef MUL_PIPE_PERF_EN
  ,
  output logic [63:0] perf_ops,
  output logic [63:0] perf_stall
`endif
);

  localparam int PW = 2 * W;

  typedef enum logic [1:0] {SEL_LO, SEL_HI, SEL_W32} sel_e;

  typedef struct packed {
    logic              vld;
    sel_e              sel;
    logic [LG_ROB-1:0] rob;
    logic [LG_PRF-1:0] prf;
  } meta_t;

  typedef struct packed {
    logic              vld;
    logic [W-1:0]      y;
    logic [LG_ROB-1:0] rob;
    logic [LG_PRF-1:0] prf;
  } out_t;

  meta_t                meta_q [LAT];
  logic signed [W:0]    a_q, b_q;
  logic [PW-1:0]        prod_q [1:LAT-1];
  out_t                 out_q;

  logic                 stall;
  logic                 a_sgn, b_sgn, is_w;
  sel_e                 sel_in;
  logic signed [W:0]    a_ext, b_ext;
  logic signed [PW-1:0] a_wide, b_wide;
  logic [W-1:0]         y_nxt;

  assign stall            = out_q.vld & ~bus.out_ready;
  assign bus.in_ready     = ~stall;
  assign bus.complete     = out_q.vld;
  assign bus.y            = out_q.y;
  assign bus.rob_ptr_out  = out_q.rob;
  assign bus.prf_ptr_out  = out_q.prf;

  // Operand extension to W+1 bits lets a single signed multiplier cover every signedness mix.
  always_comb begin
    a_sgn  = 1'b0;
    b_sgn  = 1'b0;
    is_w   = 1'b0;
    sel_in = SEL_LO;
    case (bus.op)
      3'd1: begin a_sgn = 1'b1; b_sgn = 1'b1; sel_in = SEL_HI; end
      3'd2: begin a_sgn = 1'b1; sel_in = SEL_HI; end
      3'd3: sel_in = SEL_HI;
      3'd4: begin
        a_sgn  = 1'b1;
        b_sgn  = 1'b1;
        is_w   = (W != 32);
        sel_in = (W == 32) ? SEL_LO : SEL_W32;
      end
      default: ;
    endcase
    if (is_w) begin
      a_ext = (W+1)'($signed(bus.src_a[31:0]));
      b_ext = (W+1)'($signed(bus.src_b[31:0]));
    end else begin
      a_ext = {a_sgn & bus.src_a[W-1], bus.src_a};
      b_ext = {b_sgn & bus.src_b[W-1], bus.src_b};
    end
  end

  // Sign-extending to 2W keeps the low 2W product bits exact without the unused top bits.
  always_comb begin
    a_wide = PW'(a_q);
    b_wide = PW'(b_q);
  end

  always_comb begin
    case (meta_q[LAT-1].sel)
      SEL_HI:  y_nxt = prod_q[LAT-1][PW-1:W];
      SEL_W32: y_nxt = W'($signed(prod_q[LAT-1][31:0]));
      default: y_nxt = prod_q[LAT-1][W-1:0];
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < LAT; k++) meta_q[k] <= '0;
      for (int k = 1; k < LAT; k++) prod_q[k] <= '0;
      a_q   <= '0;
      b_q   <= '0;
      out_q <= '0;
    end else if (flush) begin
      for (int k = 0; k < LAT; k++) meta_q[k].vld <= 1'b0;
      out_q.vld <= 1'b0;
    end else if (!stall) begin
      meta_q[0] <= '{vld: bus.go, sel: sel_in, rob: bus.rob_ptr_in, prf: bus.prf_ptr_in};
      a_q       <= a_ext;
      b_q       <= b_ext;
      for (int k = 1; k < LAT; k++) meta_q[k] <= meta_q[k-1];
      prod_q[1] <= a_wide * b_wide;
      for (int k = 2; k < LAT; k++) prod_q[k] <= prod_q[k-1];
      out_q     <= '{vld: meta_q[LAT-1].vld, y: y_nxt,
                     rob: meta_q[LAT-1].rob, prf: meta_q[LAT-1].prf};
    end
  end

`ifdef MUL_PIPE_PERF_EN
  // A go coinciding with flush never enters the pipe, so it is not counted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_ops   <= '0;
      perf_stall <= '0;
    end else begin
      if (bus.go & ~stall & ~flush) perf_ops <= perf_ops + 64'd1;
      if (stall) perf_stall <= perf_stall + 64'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mul_pipe.sv
// Self-checking bench for mul_pipe: directed corner cases plus randomized traffic against an arithmetic model.
module tb_mul_pipe;
  localparam int W      = 64;
  localparam int LAT    = 4;
  localparam int LG_ROB = 6;
  localparam int LG_PRF = 7;
  localparam int N_RND  = 150;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic flush = 1'b0;

  always #5 clk = ~clk;

  mul_pipe_if #(.W(W), .LG_ROB(LG_ROB), .LG_PRF(LG_PRF)) bus ();

`ifdef MUL_PIPE_PERF_EN
  logic [63:0] perf_ops;
  logic [63:0] perf_stall;
`endif

  mul_pipe #(.W(W), .LAT(LAT), .LG_ROB(LG_ROB), .LG_PRF(LG_PRF)) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus)
`ifdef MUL_PIPE_PERF_EN
    ,
    .perf_ops   (perf_ops),
    .perf_stall (perf_stall)
`endif
  );

  typedef struct packed {
    logic [63:0] y;
    logic [5:0]  rob;
    logic [6:0]  prf;
  } exp_t;

  exp_t q[$];
  exp_t e;
  exp_t held;
  int   n_assert = 0;
  int   n_fail   = 0;
  int   issued   = 0;
  int   lat;
  logic seen;
  logic prev_stall;
  logic [63:0] y_hold;

  // Reference: plain 128-bit arithmetic on the architectural definitions.
  function automatic logic [63:0] model(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
    logic signed [127:0] sa, sb, ua, ub;
    logic [127:0]        p;
    logic [31:0]         lw;
    sa = $signed(a);
    sb = $signed(b);
    ua = {64'b0, a};
    ub = {64'b0, b};
    case (op)
      3'd1: begin p = sa * sb; return p[127:64]; end
      3'd2: begin p = sa * ub; return p[127:64]; end
      3'd3: begin p = ua * ub; return p[127:64]; end
      3'd4: begin lw = a[31:0] * b[31:0]; return {{32{lw[31]}}, lw}; end
      default: return a * b;
    endcase
  endfunction

  function automatic logic [63:0] pick();
    case ($urandom_range(0, 5))
      0: return 64'hFFFF_FFFF_FFFF_FFFF;
      1: return 64'h8000_0000_0000_0000;
      2: return 64'h0000_0000_8000_0000;
      3: return 64'({$urandom_range(0, 15)});
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic g, input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                       input logic [5:0] rob, input logic [6:0] prf);
    bus.go         = g;
    bus.op         = op;
    bus.src_a      = a;
    bus.src_b      = b;
    bus.rob_ptr_in = rob;
    bus.prf_ptr_in = prf;
  endtask

  // Issue one op into an empty pipe and check latency, data and tags, then consume it.
  task automatic run_one(input string tag, input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                         input logic [5:0] rob, input logic [6:0] prf, input logic [63:0] exp_y);
    int l;
    drive(1'b1, op, a, b, rob, prf);
    tick();
    bus.go = 1'b0;
    l = 0;
    while (bus.complete !== 1'b1 && l < LAT + 10) begin
      tick();
      l++;
    end
    check({tag, "_lat"}, 64'(l), 64'(LAT));
    check({tag, "_y"}, bus.y, exp_y);
    check({tag, "_rob"}, 64'(bus.rob_ptr_out), 64'(rob));
    check({tag, "_prf"}, 64'(bus.prf_ptr_out), 64'(prf));
    tick();
    check({tag, "_consumed"}, 64'(bus.complete), 64'd0);
  endtask

  initial begin
    drive(1'b0, 3'd0, '0, '0, '0, '0);
    bus.out_ready = 1'b1;
    prev_stall    = 1'b0;
    held          = '0;

    // Reset state
    tick();
    tick();
    check("rst_complete", 64'(bus.complete), 64'd0);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_y", bus.y, 64'd0);
    check("rst_rob", 64'(bus.rob_ptr_out), 64'd0);
    check("rst_prf", 64'(bus.prf_ptr_out), 64'd0);
    reset = 1'b1;
    tick();

    // Directed arithmetic corners
    run_one("mul", 3'd0, 64'd3, 64'd5, 6'h15, 7'h4A, 64'd15);
    run_one("mulh", 3'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 6'h01, 7'h02, 64'd0);
    run_one("mulhu", 3'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 6'h03, 7'h04,
            64'hFFFF_FFFF_FFFF_FFFE);
    run_one("mulhsu", 3'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 6'h05, 7'h06, 64'hFFFF_FFFF_FFFF_FFFF);
    run_one("mulw", 3'd4, 64'h0000_0000_8000_0000, 64'd1, 6'h07, 7'h08, 64'hFFFF_FFFF_8000_0000);
    run_one("mulw_hi", 3'd4, 64'h1234_5678_8000_0000, 64'hABCD_0000_0000_0001, 6'h09, 7'h0A,
            64'hFFFF_FFFF_8000_0000);
    run_one("rsvd", 3'd6, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 6'h0B, 7'h0C, 64'hFFFF_FFFF_FFFF_FFFD);

    // Back-to-back issues with a two-cycle writeback stall
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, 3'd0, 64'(i), 64'd100, 6'(i), 7'(i + 16));
      tick();
    end
    bus.go = 1'b0;
    lat = 0;
    while (bus.complete !== 1'b1 && lat < LAT + 10) begin
      tick();
      lat++;
    end
    check("stall_first_lat", 64'(lat), 64'(LAT - 2));
    bus.out_ready = 1'b0;
    #1;
    check("stall_in_ready0", 64'(bus.in_ready), 64'd0);
    y_hold = bus.y;
    tick();
    check("stall_in_ready1", 64'(bus.in_ready), 64'd0);
    check("stall_hold_y", bus.y, y_hold);
    check("stall_hold_rob", 64'(bus.rob_ptr_out), 64'd1);
    tick();
    bus.out_ready = 1'b1;
    #1;
    check("stall_release_rdy", 64'(bus.in_ready), 64'd1);
    for (int i = 1; i <= 3; i++) begin
      check("stall_order_vld", 64'(bus.complete), 64'd1);
      check("stall_order_rob", 64'(bus.rob_ptr_out), 64'(i));
      check("stall_order_y", bus.y, 64'(i * 100));
      tick();
    end
    check("stall_no_dup", 64'(bus.complete), 64'd0);

    // Flush with ops in flight and a simultaneous go
    drive(1'b1, 3'd0, 64'd7, 64'd7, 6'd7, 7'd7);
    tick();
    drive(1'b1, 3'd0, 64'd8, 64'd8, 6'd8, 7'd8);
    tick();
    drive(1'b1, 3'd0, 64'd9, 64'd9, 6'd9, 7'd9);
    flush = 1'b1;
    tick();
    flush  = 1'b0;
    bus.go = 1'b0;
    seen   = 1'b0;
    for (int i = 0; i < LAT + 4; i++) begin
      seen |= bus.complete;
      tick();
    end
    check("flush_no_complete", 64'(seen), 64'd0);
    run_one("post_flush", 3'd0, 64'd6, 64'd7, 6'h2A, 7'h55, 64'd42);

    // Randomized traffic with random backpressure and occasional flush
    for (int cyc = 0; cyc < 4000 && (issued < N_RND || q.size() != 0); cyc++) begin
      drive((issued < N_RND) && ($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), pick(), pick(),
            6'(issued), 7'($urandom_range(0, 127)));
      bus.out_ready = ($urandom_range(0, 2) != 0);
      flush         = ($urandom_range(0, 39) == 0);
      #1;
      check("rnd_in_ready", 64'(bus.in_ready), 64'(!(bus.complete && !bus.out_ready)));
      if (prev_stall) begin
        check("rnd_hold_y", bus.y, held.y);
        check("rnd_hold_rob", 64'(bus.rob_ptr_out), 64'(held.rob));
      end
      if (flush) begin
        q.delete();
      end else begin
        if (bus.complete && bus.out_ready) begin
          if (q.size() == 0) begin
            check("rnd_spurious", 64'(bus.complete), 64'd0);
          end else begin
            e = q.pop_front();
            check("rnd_y", bus.y, e.y);
            check("rnd_rob", 64'(bus.rob_ptr_out), 64'(e.rob));
            check("rnd_prf", 64'(bus.prf_ptr_out), 64'(e.prf));
          end
        end
        if (bus.go && bus.in_ready) begin
          q.push_back('{model(bus.op, bus.src_a, bus.src_b), bus.rob_ptr_in, bus.prf_ptr_in});
          issued++;
        end
      end
      prev_stall = bus.complete && !bus.out_ready && !flush;
      held       = '{bus.y, bus.rob_ptr_out, bus.prf_ptr_out};
      tick();
    end
    flush         = 1'b0;
    bus.go        = 1'b0;
    bus.out_ready = 1'b1;
    check("rnd_drained", 64'(q.size()), 64'd0);
    check("rnd_issued", 64'(issued), 64'(N_RND));
    tick();

    // Asynchronous reset with ops in flight and the output stalled
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 3'd3, pick(), pick(), 6'(i + 40), 7'(i + 80));
      tick();
    end
    bus.go = 1'b0;
    lat = 0;
    while (bus.complete !== 1'b1 && lat < LAT + 10) begin
      tick();
      lat++;
    end
    check("rst_mid_complete_pre", 64'(bus.complete), 64'd1);
    tick();
    reset = 1'b0;
    #1;
    check("rst_mid_complete", 64'(bus.complete), 64'd0);
    check("rst_mid_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_mid_y", bus.y, 64'd0);
    check("rst_mid_rob", 64'(bus.rob_ptr_out), 64'd0);
`ifdef MUL_PIPE_PERF_EN
    check("rst_perf_ops", perf_ops, 64'd0);
    check("rst_perf_stall", perf_stall, 64'd0);
`endif
    tick();
    tick();
    reset         = 1'b1;
    bus.out_ready = 1'b1;
    seen          = 1'b0;
    for (int i = 0; i < LAT + 4; i++) begin
      tick();
      seen |= bus.complete;
    end
    check("rst_no_spurious", 64'(seen), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
